alu_seq: RTL
============

# alu_seq

Parametrised, multi-cycle successor to the 9-bit single-cycle datapath ALU. Computes add, subtract, logic ops and compare in one cycle, and performs variable-distance logical shifts iteratively, one bit per cycle, with a shift-in fill bit. It sits between the register file read ports and the write-back/branch logic. A start/busy/done handshake lets the controller stall for shifts while single-cycle ops run back-to-back.

## Interface
- W, default 9: datapath width in bits (W ≥ 2).
- CW, default $clog2(W+1): width of the internal shift counter.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy is low.
- alu_cmd  in  3  operation, alu_op_t encoding.
- inA  in  W  operand A / shift source.
- inB  in  W  operand B / shift distance (unsigned).
- sc_i  in  1  shift fill bit, latched at accept.
- busy  out  1  high while a shift is iterating.
- done  out  1  one-cycle pulse: rslt/flag updated.
- rslt  out  W  registered result, held until next done.
- flag  out  1  registered jump/status flag, held with rslt.

## Operation
- Encoding: 000 ADD, 001 LSL, 010 LSR, 011 XOR, 100 AND, 101 OR, 110 SUB, 111 CMP.
- Accept: start && !busy at a rising edge latches alu_cmd, inA, inB, sc_i. start while busy is ignored, no queuing.
- ADD: rslt = (inA+inB) mod 2^W; flag = carry out of bit W-1.
- SUB: rslt = (inA−inB) mod 2^W; flag = 1 iff inB > inA (borrow, unsigned).
- XOR/AND/OR: bitwise; flag = 0.
- CMP: rslt = 0; flag = 1 iff inA == inB.
- LSL/LSR: k = min(inB, W). Shift register loaded with inA; each SHIFT cycle shifts one place, fill = latched sc_i (LSL fills bit 0, LSR fills bit W-1); flag = last bit shifted out. k = 0: rslt = inA, flag = 0, single-cycle. inB ≥ W clamps to W (all bits replaced by fill).
- FSM: IDLE, SHIFT. IDLE + accept of non-shift or k = 0: result registered, done = 1, stay IDLE. IDLE + accept of shift with k ≥ 1: load shifter, counter = k, go SHIFT. SHIFT: shift, decrement; on the shift with counter = 1, write rslt/flag, done = 1, go IDLE.
- rslt/flag never show intermediate shift values; they change only on done edges.
- Unused encodings: none; all 8 codes defined.

## Timing
- Reset: state IDLE, busy 0, done 0, rslt 0, flag 0, counter 0, shifter 0.
- Cycle 0 = cycle in which start is sampled high with busy low.
- Non-shift, or shift with k = 0: done high in cycle 1, rslt/flag valid from cycle 1; busy stays 0.
- Shift with k ≥ 1: busy high cycles 1..k; done high in cycle k+1; busy low in cycle k+1.
- Back-to-back: start in any cycle with busy low (including a done cycle) is accepted; throughput 1 op/cycle for non-shift ops.
- done is exactly one cycle; never high while busy is high.
- reset mid-SHIFT: next cycle IDLE, busy 0, done 0, rslt 0, flag 0; operation dropped. reset wins over a simultaneous start.
- Operand inputs may change freely after the accept edge.

## Structure
- Shared package alu_pkg: typedef enum logic [2:0] alu_op_t (ALU_ADD … ALU_CMP), typedef enum state_t {IDLE, SHIFT}, localparam ALU_W = 9 default width.
- One natural sub-module: alu_core, combinational W-bit ADD/SUB/XOR/AND/OR/CMP with flag, instantiated by alu_seq; shifter, counter and FSM live in alu_seq.

## Test plan
- W=9, ADD 9'h1FF + 9'h001 -> done at cycle 1, rslt 9'h000, flag 1, busy never high.
- SUB 9'h005 − 9'h007 -> rslt 9'h1FE, flag 1; then CMP 9'h0AA vs 9'h0AA issued in the done cycle -> next done, rslt 0, flag 1.
- LSL 9'h181 by 2, sc_i 0 -> busy cycles 1–2, done cycle 3, rslt 9'h004, flag 1; start pulsed in cycle 1 ignored.
- LSR 9'h003 by 12, sc_i 1 -> clamped to 9, busy cycles 1–9, done cycle 10, rslt 9'h1FF, flag 0.
- LSL 9'h0F0 by 0 -> done cycle 1, rslt 9'h0F0, flag 0, busy never high.
- LSR by 5 then reset in cycle 3 -> cycle 4: busy 0, done 0, rslt 0, flag 0; no done pulse thereafter.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and defaults for the sequential ALU and its combinational core.
package alu_pkg;

  localparam int ALU_W = 9;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_LSL = 3'b001,
    ALU_LSR = 3'b010,
    ALU_XOR = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_SUB = 3'b110,
    ALU_CMP = 3'b111
  } alu_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Shifts are the only ops that may take more than one cycle.
  function automatic logic is_shift(alu_op_t op);
    return (op == ALU_LSL) || (op == ALU_LSR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle W-bit arithmetic/logic/compare datapath with status flag.
// Shift opcodes pass operand A through with flag 0, which is exactly the
// zero-distance shift result, so the sequencer can reuse this path for k = 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  alu_op_t        op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [W-1:0]   res_o,
  output logic           flag_o
);

  logic [W:0] sum;
  logic [W:0] diff;

  // One extra bit captures carry (add) and borrow (subtract).
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  // Result/flag select by opcode.
  always_comb begin
    res_o  = '0;
    flag_o = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        res_o  = sum[W-1:0];
        flag_o = sum[W];
      end
      ALU_SUB: begin
        res_o  = diff[W-1:0];
        flag_o = diff[W];
      end
      ALU_XOR: res_o = a_i ^ b_i;
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_CMP: flag_o = (a_i == b_i);
      ALU_LSL,
      ALU_LSR: res_o = a_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops through alu_core, logical shifts iterated
// one bit per cycle with a latched fill bit. Result and flag are held in
// registers that only move on a done pulse.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W  = ALU_W,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rslt,
  output logic         flag
);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]  sh_q,    sh_d;
  logic          fill_q,  fill_d;
  logic          left_q,  left_d;
  logic [W-1:0]  rslt_q,  rslt_d;
  logic          flag_q,  flag_d;
  logic          done_q,  done_d;

  alu_op_t       op_in;
  logic          accept;
  logic [CW-1:0] k_in;
  logic [W-1:0]  core_res;
  logic          core_flag;
  logic [W-1:0]  sh_next;
  logic          out_bit;

  assign op_in  = alu_op_t'(alu_cmd);
  assign accept = start && (state_q == IDLE);

  // Distance clamps at W: every original bit has been replaced by fill by then.
  assign k_in = (inB >= W'(W)) ? CW'(W) : CW'(inB);

  alu_core #(.W(W)) u_core (
    .op_i   (op_in),
    .a_i    (inA),
    .b_i    (inB),
    .res_o  (core_res),
    .flag_o (core_flag)
  );

  // One-place shift of the working register and the bit that falls off.
  assign sh_next = left_q ? {sh_q[W-2:0], fill_q} : {fill_q, sh_q[W-1:1]};
  assign out_bit = left_q ? sh_q[W-1] : sh_q[0];

  // Next-state: accept in IDLE, iterate in SHIFT, publish result on the last step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    fill_d  = fill_q;
    left_d  = left_q;
    rslt_d  = rslt_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift(op_in) && (k_in != '0)) begin
            sh_d    = inA;
            cnt_d   = k_in;
            fill_d  = sc_i;
            left_d  = (op_in == ALU_LSL);
            state_d = SHIFT;
          end else begin
            rslt_d = core_res;
            flag_d = core_flag;
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          rslt_d  = sh_next;
          flag_d  = out_bit;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything and drops any shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      fill_q  <= 1'b0;
      left_q  <= 1'b0;
      rslt_q  <= '0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      fill_q  <= fill_d;
      left_q  <= left_d;
      rslt_q  <= rslt_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign rslt = rslt_q;
  assign flag = flag_q;

endmodule
